dest_reg_scoreboard: RTL and testbench

//  Consumer side of the 5-bit destination-register selection (rt/rd) made in ID.

---
 rtl/dest_reg_scoreboard_if.sv | 33 +++
 rtl/dest_reg_scoreboard.sv | 85 ++++++++
 tb/tb_dest_reg_scoreboard.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dest_reg_scoreboard_if.sv
// Issue/retire/flush bundle between ID, WB and the destination-register scoreboard.
// master: ID/WB side (drives issue, retire, flush). slave: scoreboard (drives stall/status).
interface dest_reg_scoreboard_if #(
   parameter int ADDR_W = 5,
   parameter int TOT_W  = 6
);
   logic              iss_valid;
   logic              iss_wr_en;
   logic [ADDR_W-1:0] iss_dst;
   logic [ADDR_W-1:0] iss_src_a;
   logic [ADDR_W-1:0] iss_src_b;
   logic              iss_use_b;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_dst;
   logic              flush;
   logic              stall;
   logic              busy_a;
   logic              busy_b;
   logic [TOT_W-1:0]  in_flight;
   logic              retire_err;

   modport master (
      output iss_valid, iss_wr_en, iss_dst, iss_src_a, iss_src_b, iss_use_b,
      output wb_valid, wb_dst, flush,
      input  stall, busy_a, busy_b, in_flight, retire_err
   );

   modport slave (
      input  iss_valid, iss_wr_en, iss_dst, iss_src_a, iss_src_b, iss_use_b,
      input  wb_valid, wb_dst, flush,
      output stall, busy_a, busy_b, in_flight, retire_err
   );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Tracks pending register writes between issue and writeback; stalls RAW hazards.
// Ports: clk, rst (sync active-low), bus (slave: issue, retire, flush in; stall/busy/in_flight/retire_err out).
module dest_reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 2,
   parameter int TOT_W    = 6
) (
   input logic clk,
   input logic rst,
   dest_reg_scoreboard_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
   logic [CNT_W-1:0] cnt   [NUM_REGS];
   logic [CNT_W-1:0] eff   [NUM_REGS];
   logic             dec   [NUM_REGS];
   logic [TOT_W-1:0] in_flight_q;
   logic             retire_err_q;
   logic             sat;
   logic             accept;
   logic             any_inc;
   logic             any_dec;
   logic             bad_retire;

   // Register 0 reads as a constant zero count.
   always_comb begin
      cnt[0] = '0;
      for (int r = 1; r < NUM_REGS; r++) cnt[r] = cnt_q[r];
   end

   // Retire bypass: a register retiring this cycle is seen with one fewer pending write.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         dec[r] = bus.wb_valid && (bus.wb_dst == ADDR_W'(r)) &&
                  (r != 0) && (cnt[r] != '0);
         eff[r] = dec[r] ? cnt[r] - CNT_W'(1) : cnt[r];
      end
   end

   always_comb begin
      bus.busy_a = bus.iss_valid && (bus.iss_src_a != '0) &&
                   (eff[bus.iss_src_a] != '0);
      bus.busy_b = bus.iss_valid && bus.iss_use_b &&
                   (bus.iss_src_b != '0) && (eff[bus.iss_src_b] != '0);
      sat        = bus.iss_valid && bus.iss_wr_en && (bus.iss_dst != '0) &&
                   (cnt[bus.iss_dst] == CNT_MAX) && !dec[bus.iss_dst];
      bus.stall  = !bus.flush && (bus.busy_a || bus.busy_b || sat);
      accept     = bus.iss_valid && !bus.stall && !bus.flush;
      any_inc    = accept && bus.iss_wr_en && (bus.iss_dst != '0);
      any_dec    = dec[bus.wb_dst];
      bad_retire = bus.wb_valid && (bus.wb_dst != '0) &&
                   (cnt[bus.wb_dst] == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
         in_flight_q  <= '0;
         retire_err_q <= 1'b0;
      end else if (bus.flush) begin
         for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
         in_flight_q <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            // Simultaneous issue and retire on one register cancel out.
            if (any_inc && (bus.iss_dst == ADDR_W'(r)) && !dec[r])
               cnt_q[r] <= cnt_q[r] + CNT_W'(1);
            else if (dec[r] && !(any_inc && (bus.iss_dst == ADDR_W'(r))))
               cnt_q[r] <= cnt_q[r] - CNT_W'(1);
         end
         if (any_inc && !any_dec)
            in_flight_q <= in_flight_q + TOT_W'(1);
         else if (any_dec && !any_inc)
            in_flight_q <= in_flight_q - TOT_W'(1);
         if (bad_retire)
            retire_err_q <= 1'b1;
      end
   end

   assign bus.in_flight  = in_flight_q;
   assign bus.retire_err = retire_err_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard.
// Inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
module tb_dest_reg_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dest_reg_scoreboard_if #(.ADDR_W(5), .TOT_W(6)) bus ();

   dest_reg_scoreboard #(
      .NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .TOT_W(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid = 0; bus.iss_wr_en = 0; bus.iss_dst = 0;
      bus.iss_src_a = 0; bus.iss_src_b = 0; bus.iss_use_b = 0;
      bus.wb_valid = 0;  bus.wb_dst = 0;    bus.flush = 0;
   endtask

   task automatic issue(input int dst, input int sa);
      idle();
      bus.iss_valid = 1; bus.iss_wr_en = 1;
      bus.iss_dst = 5'(dst); bus.iss_src_a = 5'(sa);
   endtask

   task automatic retire(input int dst);
      idle();
      bus.wb_valid = 1; bus.wb_dst = 5'(dst);
   endtask

   initial begin
      idle();
      // 1: reset
      rst = 0; step(); step();
      rst = 1; step();
      #1;
      check("rst_inflight", int'(bus.in_flight), 0);
      check("rst_stall", int'(bus.stall), 0);
      check("rst_err", int'(bus.retire_err), 0);

      // 2: RAW on $8 with WB bypass
      issue(8, 0); #1;
      check("t2_iss_stall", int'(bus.stall), 0);
      step();
      check("t2_inflight1", int'(bus.in_flight), 1);
      idle(); bus.iss_valid = 1; bus.iss_src_a = 8; #1;
      check("t2_stall", int'(bus.stall), 1);
      check("t2_busya", int'(bus.busy_a), 1);
      bus.wb_valid = 1; bus.wb_dst = 8; #1;
      check("t2_byp_stall", int'(bus.stall), 0);
      check("t2_byp_busya", int'(bus.busy_a), 0);
      step();
      check("t2_inflight0", int'(bus.in_flight), 0);

      // 3: $0 never tracked
      for (int i = 0; i < 3; i++) begin
         issue(0, 0); #1;
         check("t3_stall", int'(bus.stall), 0);
         step();
      end
      check("t3_inflight", int'(bus.in_flight), 0);
      idle(); bus.iss_valid = 1; bus.iss_use_b = 1; #1;
      check("t3_src0_stall", int'(bus.stall), 0);
      retire(0); step();
      check("t3_wb0_err", int'(bus.retire_err), 0);

      // 4: saturation on $5
      for (int i = 0; i < 3; i++) begin
         issue(5, 0); step();
      end
      check("t4_inflight3", int'(bus.in_flight), 3);
      issue(5, 0); #1;
      check("t4_sat_stall", int'(bus.stall), 1);
      bus.wb_valid = 1; bus.wb_dst = 5; #1;
      check("t4_sat_byp", int'(bus.stall), 0);
      step();
      check("t4_hold_inflight", int'(bus.in_flight), 3);
      issue(5, 0); #1;
      check("t4_still_sat", int'(bus.stall), 1);
      idle(); bus.iss_valid = 1; bus.iss_src_b = 5; #1;
      check("t4_busyb_gated", int'(bus.busy_b), 0);
      bus.iss_use_b = 1; #1;
      check("t4_busyb", int'(bus.busy_b), 1);
      for (int i = 0; i < 3; i++) begin
         retire(5); step();
      end
      check("t4_drain", int'(bus.in_flight), 0);
      check("t4_no_err", int'(bus.retire_err), 0);

      // self-dependency with a free source is accepted
      issue(6, 6); #1;
      check("t4_selfdep", int'(bus.stall), 0);
      step();
      check("t4_selfdep_inf", int'(bus.in_flight), 1);

      // 5: flush clears everything
      issue(3, 0); step();
      issue(4, 0); step();
      issue(9, 0); step();
      check("t5_inflight4", int'(bus.in_flight), 4);
      issue(10, 3); bus.flush = 1; #1;
      check("t5_flush_stall", int'(bus.stall), 0);
      step();
      check("t5_flush_inf", int'(bus.in_flight), 0);
      idle(); bus.iss_valid = 1; bus.iss_src_a = 3; #1;
      check("t5_busya", int'(bus.busy_a), 0);
      check("t5_stall", int'(bus.stall), 0);

      // 6: sticky retire error, reset mid-stall
      retire(12); step();
      check("t6_err", int'(bus.retire_err), 1);
      idle(); step();
      check("t6_err_sticky", int'(bus.retire_err), 1);
      issue(7, 0); step();
      idle(); bus.iss_valid = 1; bus.iss_src_a = 7; #1;
      check("t6_pre_stall", int'(bus.stall), 1);
      rst = 0; step();
      check("t6_rst_stall", int'(bus.stall), 0);
      check("t6_rst_err", int'(bus.retire_err), 0);
      check("t6_rst_inf", int'(bus.in_flight), 0);
      rst = 1; idle(); step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
